rc4_phase_ctrl: RTL and testbench

Top-level sequencer for the RC4 key-search datapath. It runs the three S-memory phase engines in order for each candidate key: S-array init, key-scheduling shuffle, then decrypt/check. It also multiplexes their address, data and write-enable ports onto the single-port 256x8 S RAM. It steps the candidate key until the decrypt engine reports a valid plaintext or the key space is exhausted.

---
 rtl/rc4_phase_ctrl.sv | 138 +++++++++++++
 tb/tb_rc4_phase_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_phase_ctrl.sv
// RC4 key-search sequencer: steps init -> shuffle -> decrypt engines per candidate
// key and multiplexes the active engine onto the single-port S RAM.
module rc4_phase_ctrl #(
  parameter int KEY_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             single,
  input  logic [KEY_W-1:0] key_in,
  output logic             init_start,
  output logic             shuf_start,
  output logic             dec_start,
  input  logic             init_finish,
  input  logic             shuf_finish,
  input  logic             dec_finish,
  input  logic             dec_match,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       shuf_addr,
  input  logic [7:0]       dec_addr,
  input  logic [7:0]       init_data,
  input  logic [7:0]       shuf_data,
  input  logic [7:0]       dec_data,
  input  logic             init_wren,
  input  logic             shuf_wren,
  input  logic             dec_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_data,
  output logic             s_wren,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
  output logic             found,
  output logic             fail,
  output logic [1:0]       phase,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_GO   = 4'd1,
    INIT_WAIT = 4'd2,
    SHUF_GO   = 4'd3,
    SHUF_WAIT = 4'd4,
    DEC_GO    = 4'd5,
    DEC_WAIT  = 4'd6,
    NEXT_KEY  = 4'd7,
    FOUND     = 4'd8,
    FAIL      = 4'd9
  } state_t;

  state_t state;
  state_t state_d;
  logic   single_q;
  logic   accept_start;

  assign accept_start = (state == IDLE) || (state == FOUND) || (state == FAIL);
  assign dbg_state    = state;

  // Finish inputs only count in their owner's WAIT state; start only when parked.
  always_comb begin
    state_d = state;
    case (state)
      IDLE, FOUND, FAIL: if (start) state_d = INIT_GO;
      INIT_GO:           state_d = INIT_WAIT;
      INIT_WAIT:         if (init_finish) state_d = SHUF_GO;
      SHUF_GO:           state_d = SHUF_WAIT;
      SHUF_WAIT:         if (shuf_finish) state_d = DEC_GO;
      DEC_GO:            state_d = DEC_WAIT;
      DEC_WAIT: begin
        if (dec_finish) begin
          if (dec_match)                    state_d = FOUND;
          else if (single_q || (&key_out))  state_d = FAIL;
          else                              state_d = NEXT_KEY;
        end
      end
      NEXT_KEY:          state_d = INIT_GO;
      default:           state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      key_out    <= '0;
      single_q   <= 1'b0;
      init_start <= 1'b0;
      shuf_start <= 1'b0;
      dec_start  <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_d;
      init_start <= (state_d == INIT_GO);
      shuf_start <= (state_d == SHUF_GO);
      dec_start  <= (state_d == DEC_GO);
      busy       <= !((state_d == IDLE) || (state_d == FOUND) || (state_d == FAIL));
      found      <= (state_d == FOUND);
      fail       <= (state_d == FAIL);
      if (accept_start && start) begin
        key_out  <= key_in;
        single_q <= single;
      end else if (state == NEXT_KEY) begin
        key_out  <= key_out + {{(KEY_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    s_addr = 8'h00;
    s_data = 8'h00;
    s_wren = 1'b0;
    phase  = 2'd0;
    case (state)
      INIT_GO, INIT_WAIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
        phase  = 2'd1;
      end
      SHUF_GO, SHUF_WAIT: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
        phase  = 2'd2;
      end
      DEC_GO, DEC_WAIT: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
        phase  = 2'd3;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: engine latency models, start-pulse scoreboard,
// per-cycle RAM mux checks, vector table plus hand-written corner sequences.
module tb_rc4_phase_ctrl;
  localparam int KEY_W = 22;
  localparam int INIT_LAT = 256;
  localparam int SHUF_LAT = 768;
  localparam int DEC_LAT = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic single = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic init_start, shuf_start, dec_start;
  logic init_finish, shuf_finish, dec_finish, dec_match;
  logic [7:0] s_addr, s_data;
  logic s_wren;
  logic [KEY_W-1:0] key_out;
  logic busy, found, fail;
  logic [1:0] phase;
  logic [3:0] dbg_state;

  logic [3:0] fin_m = '0;
  logic dec_match_m = 1'b0;
  logic stray_shuf = 1'b0, stray_dec = 1'b0;
  assign init_finish = fin_m[1];
  assign shuf_finish = fin_m[2] | stray_shuf;
  assign dec_finish  = fin_m[3] | stray_dec;
  assign dec_match   = dec_match_m | stray_dec;

  rc4_phase_ctrl #(.KEY_W(KEY_W)) dut (
    .clk(clk), .reset(reset), .start(start), .single(single), .key_in(key_in),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_finish(init_finish), .shuf_finish(shuf_finish), .dec_finish(dec_finish),
    .dec_match(dec_match),
    .init_addr(8'hA1), .shuf_addr(8'hA2), .dec_addr(8'hA3),
    .init_data(8'h51), .shuf_data(8'h52), .dec_data(8'h53),
    .init_wren(1'b1), .shuf_wren(1'b1), .dec_wren(1'b1),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren), .key_out(key_out),
    .busy(busy), .found(found), .fail(fail), .phase(phase), .dbg_state(dbg_state)
  );

  // Clock and reset-sampling block
  always #5 clk = ~clk;
  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= reset;

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  int cur_mode = 0;             // 0 never match, 1 always, 2 match on key
  logic [KEY_W-1:0] cur_mkey = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + engine models. Owner tracking uses the model's own finish pulses.
  int owner = 0;
  int cnt[4] = '{0, 0, 0, 0};
  logic [3:0] prev_st = '0;
  logic prev_found = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    logic [3:0] st;
    logic [1:0] id;
    int nst;
    st = {dec_start, shuf_start, init_start, 1'b0};
    nst = int'(st[1]) + int'(st[2]) + int'(st[3]);
    if (rst_q) owner = 0;
    if (nst != 0) begin
      chk("one_start_at_a_time", nst, 1);
      id = st[1] ? 2'd1 : (st[2] ? 2'd2 : 2'd3);
      if (exp_q.size() == 0) chk("unexpected_start", {30'd0, id}, 0);
      else chk("start_order", {30'd0, id}, {30'd0, exp_q.pop_front()});
      chk("start_width", {28'd0, st & prev_st}, 0);
      owner = id;
    end else if (fin_m[owner]) begin
      owner = 0;
    end
    chk("mux_addr", {24'd0, s_addr}, owner != 0 ? 32'hA0 + owner : 32'h0);
    chk("mux_data", {24'd0, s_data}, owner != 0 ? 32'h50 + owner : 32'h0);
    chk("mux_wren", {31'd0, s_wren}, {31'd0, owner != 0});
    chk("phase", {30'd0, phase}, owner);
    if (found && !prev_found) chk("busy_falls_with_found", {30'd0, prev_busy, busy}, 32'h2);
    prev_st = st;
    prev_found = found;
    prev_busy = busy;
    for (int e = 1; e <= 3; e++) begin
      if (st[e]) begin
        cnt[e] = (e == 1) ? INIT_LAT : (e == 2) ? SHUF_LAT : DEC_LAT;
        fin_m[e] = 1'b0;
      end else if (cnt[e] > 0) begin
        cnt[e]--;
        fin_m[e] = (cnt[e] == 0);
      end else begin
        fin_m[e] = 1'b0;
      end
    end
    dec_match_m = fin_m[3] && (cur_mode == 1 || (cur_mode == 2 && key_out == cur_mkey));
  end

  // Driver tasks
  task automatic start_run(input logic sgl, input logic [KEY_W-1:0] key, input int mode,
                           input logic [KEY_W-1:0] mkey, input int ntrip);
    cur_mode = mode;
    cur_mkey = mkey;
    for (int i = 0; i < ntrip; i++) begin
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
    end
    @(posedge clk); #1;
    single = sgl; key_in = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = ~key;
    @(negedge clk);
    chk("init_start_after_start", {31'd0, init_start}, 1);
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("key_loaded", {10'd0, key_out}, {10'd0, key});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(found || fail) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, n >= 20000}, 0);
  endtask

  task automatic wait_owner(input int k);
    int n;
    n = 0;
    while (owner != k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("owner_timeout", {31'd0, n >= 2000}, 0);
  endtask

  task automatic check_end(input string tag, input logic f, input logic fl, input logic [KEY_W-1:0] k);
    chk({tag, "_found"}, {31'd0, found}, {31'd0, f});
    chk({tag, "_fail"}, {31'd0, fail}, {31'd0, fl});
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_key"}, {10'd0, key_out}, {10'd0, k});
    repeat (40) @(negedge clk);
    chk({tag, "_held"}, {30'd0, found, fail}, {30'd0, f, fl});
    chk({tag, "_key_stable"}, {10'd0, key_out}, {10'd0, k});
    chk({tag, "_pulses_left"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic             sgl;
    logic [KEY_W-1:0] key;
    int               mode;
    logic [KEY_W-1:0] mkey;
    int               ntrip;
    logic             e_found;
    logic             e_fail;
    logic [KEY_W-1:0] e_key;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 22'h000249, 1, 22'h0,      1, 1'b1, 1'b0, 22'h000249};
    vecs[1] = '{1'b0, 22'h000000, 2, 22'h3,      4, 1'b1, 1'b0, 22'h000003};
    vecs[2] = '{1'b0, 22'h3FFFFE, 0, 22'h0,      2, 1'b0, 1'b1, 22'h3FFFFF};
    vecs[3] = '{1'b1, 22'h012345, 0, 22'h0,      1, 1'b0, 1'b1, 22'h012345};
    vecs[4] = '{1'b0, 22'h3FFFFF, 0, 22'h0,      1, 1'b0, 1'b1, 22'h3FFFFF};
    vecs[5] = '{1'b0, 22'h000010, 2, 22'h11,     2, 1'b1, 1'b0, 22'h000011};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {24'd0, init_start, shuf_start, dec_start, busy, found, fail, s_wren, 1'b0}, 0);
    chk("rst_key", {10'd0, key_out}, 0);
    chk("rst_state", {28'd0, dbg_state}, 0);

    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i].sgl, vecs[i].key, vecs[i].mode, vecs[i].mkey, vecs[i].ntrip);
      wait_done();
      check_end($sformatf("vec%0d", i), vecs[i].e_found, vecs[i].e_fail, vecs[i].e_key);
    end

    // Stray finishes in INIT_WAIT and a stray start in SHUF_WAIT
    start_run(1'b1, 22'h7, 2, 22'h7, 1);
    wait_owner(1);
    repeat (10) @(posedge clk);
    #1 stray_shuf = 1'b1; stray_dec = 1'b1;
    @(posedge clk); #1 stray_shuf = 1'b0; stray_dec = 1'b0;
    @(negedge clk);
    chk("stray_state_init_wait", {28'd0, dbg_state}, 2);
    wait_owner(2);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; single = 1'b0; key_in = 22'h100;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("stray_state_shuf_wait", {28'd0, dbg_state}, 4);
    chk("stray_key_kept", {10'd0, key_out}, 32'h7);
    wait_done();
    check_end("stray", 1'b1, 1'b0, 22'h7);

    // Reset in DEC_WAIT, then a clean restart
    start_run(1'b0, 22'h20, 0, 22'h0, 1);
    wait_owner(3);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_outputs", {24'd0, init_start, shuf_start, dec_start, busy, found, fail, s_wren, 1'b0}, 0);
    chk("midrst_addr", {24'd0, s_addr}, 0);
    chk("midrst_key", {10'd0, key_out}, 0);
    chk("midrst_phase", {30'd0, phase}, 0);
    repeat (50) @(negedge clk);
    chk("midrst_idle", {28'd0, dbg_state}, 0);
    start_run(1'b1, 22'h5, 2, 22'h5, 1);
    wait_done();
    check_end("restart", 1'b1, 1'b0, 22'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
